wormhole_credit_arbiter: RTL and testbench

Per-output-port scheduler for the 2x2 router. It shares one output port between the input FIFOs at packet granularity: round-robin selection at packet heads, then wormhole lock to the owner until its tail flit is granted. Flit forwarding is gated by a credit counter that tracks free slots in the downstream receiver. It is instantiated once per output port, and its `grant` vector drives the FIFO pops and the output mux.

---
 rtl/router_sched_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/wormhole_credit_arbiter.sv | 145 ++++++++++++++
 tb/tb_wormhole_credit_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/router_sched_pkg.sv
// Shared scheduling types for the 2x2 router: arbiter state encoding, default
// downstream credit depth and the flit format the request wrapper decodes.
package router_sched_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    localparam int SCHED_CREDITS = 4;
    localparam int PORT_NUM_W    = 1;
    localparam int PAYLOAD_W     = 16;

    typedef struct packed {
        logic                  valid;
        logic                  tail;
        logic [PORT_NUM_W-1:0] output_port_num;
        logic [PAYLOAD_W-1:0]  payload;
    } pkt_flit_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from
// ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    // priority scan starting at ptr; found_s suppresses later hits
    always_comb begin
        logic found_s;
        int   idx_v;
        found_s  = 1'b0;
        pick     = '0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = (int'(ptr) + i) % NUM_REQ;
            if (!found_s && req[idx_v]) begin
                found_s       = 1'b1;
                pick[idx_v]   = 1'b1;
                pick_idx      = IDX_W'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/wormhole_credit_arbiter.sv
// Per-output-port wormhole scheduler: round-robin at packet heads, lock to the
// owner until its tail, every forwarded flit gated by a downstream credit.
module wormhole_credit_arbiter
    import router_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CREDITS = SCHED_CREDITS,
    parameter int CNT_W   = $clog2(CREDITS + 1),
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_tail,
    input  logic               credit_return,
    output logic [NUM_REQ-1:0] grant,
    output logic               locked,
    output logic [IDX_W-1:0]   owner,
    output logic [CNT_W-1:0]   credit_cnt,
    output logic               credit_err
);

    sched_state_t       state_r, state_next_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_next_s;
    logic [IDX_W-1:0]   owner_r, owner_next_s;
    logic [CNT_W-1:0]   credit_cnt_r, credit_cnt_next_s;
    logic               credit_err_r, credit_err_next_s;
    logic [NUM_REQ-1:0] pick_s, grant_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               can_send_s, granted_s, granted_tail_s;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .ptr      (rr_ptr_r),
        .pick     (pick_s),
        .pick_idx (pick_idx_s)
    );

    assign can_send_s     = (credit_cnt_r != CNT_W'(0));
    assign granted_s      = |grant_s;
    assign granted_tail_s = |(grant_s & req_tail);

    // grant decode; reset masks it because registers alone would leave IDLE granting
    always_comb begin
        grant_s = '0;
        case (state_r)
            IDLE: begin
                if (can_send_s && (|req)) begin
                    grant_s = pick_s;
                end else begin
                    grant_s = '0;
                end
            end
            LOCKED:  grant_s[owner_r] = req[owner_r] & can_send_s;
            default: grant_s = '0;
        endcase
        grant = rst_b ? grant_s : '0;
    end

    // packet-level next state: a head without tail locks, a granted tail releases
    always_comb begin
        state_next_s  = state_r;
        rr_ptr_next_s = rr_ptr_r;
        owner_next_s  = owner_r;
        case (state_r)
            IDLE: begin
                if (granted_s && granted_tail_s) begin
                    rr_ptr_next_s = wrap_inc(pick_idx_s);
                end else if (granted_s) begin
                    state_next_s = LOCKED;
                    owner_next_s = pick_idx_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOCKED: begin
                if (granted_s && granted_tail_s) begin
                    state_next_s  = IDLE;
                    rr_ptr_next_s = wrap_inc(owner_r);
                end else begin
                    state_next_s = LOCKED;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // credit accounting; a return into a full counter saturates and flags
    always_comb begin
        credit_cnt_next_s = credit_cnt_r;
        credit_err_next_s = credit_err_r;
        if (granted_s && !credit_return) begin
            credit_cnt_next_s = credit_cnt_r - CNT_W'(1);
        end else if (!granted_s && credit_return) begin
            if (credit_cnt_r == CNT_W'(CREDITS)) begin
                credit_err_next_s = 1'b1;
            end else begin
                credit_cnt_next_s = credit_cnt_r + CNT_W'(1);
            end
        end else begin
            credit_cnt_next_s = credit_cnt_r;
        end
    end

    // state, pointer and owner registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
        end else begin
            state_r  <= state_next_s;
            rr_ptr_r <= rr_ptr_next_s;
            owner_r  <= owner_next_s;
        end
    end

    // credit counter and sticky error registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            credit_cnt_r <= CNT_W'(CREDITS);
            credit_err_r <= 1'b0;
        end else begin
            credit_cnt_r <= credit_cnt_next_s;
            credit_err_r <= credit_err_next_s;
        end
    end

    assign locked     = (state_r == LOCKED);
    assign owner      = owner_r;
    assign credit_cnt = credit_cnt_r;
    assign credit_err = credit_err_r;

endmodule

// File: tb/tb_wormhole_credit_arbiter.sv
// Scoreboard bench for wormhole_credit_arbiter (NUM_REQ=2, CREDITS=4).
module tb_wormhole_credit_arbiter;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [1:0] req;
    logic [1:0] req_tail;
    logic       credit_return;
    logic [1:0] grant;
    logic       locked;
    logic [0:0] owner;
    logic [2:0] credit_cnt;
    logic       credit_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] grant;
        logic       locked;
        logic [0:0] owner;
        logic [2:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int m_locked, m_owner, m_ptr, m_cnt, m_err;

    wormhole_credit_arbiter #(
        .NUM_REQ (2),
        .CREDITS (4)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .req           (req),
        .req_tail      (req_tail),
        .credit_return (credit_return),
        .grant         (grant),
        .locked        (locked),
        .owner         (owner),
        .credit_cnt    (credit_cnt),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 4; m_err = 0;
    endtask

    task automatic model_grant(input logic [1:0] r, output logic [1:0] g);
        int j;
        g = 2'b00;
        if (m_cnt > 0) begin
            if (m_locked != 0) begin
                if (r[m_owner]) g[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    j = (m_ptr + k) % 2;
                    if (g == 2'b00 && r[j]) g[j] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_update(input logic [1:0] g, input logic [1:0] t, input logic cr);
        int w;
        if (g != 2'b00) begin
            w = g[1] ? 1 : 0;
            if (t[w]) begin
                m_locked = 0;
                m_ptr    = (w + 1) % 2;
            end else begin
                m_locked = 1;
                m_owner  = w;
            end
        end
        if (g != 2'b00 && !cr) m_cnt--;
        else if (g == 2'b00 && cr) begin
            if (m_cnt == 4) m_err = 1;
            else m_cnt++;
        end
    endtask

    // one clock cycle: drive, push expectation, compare at negedge, advance model
    task automatic cyc(input logic [1:0] r, input logic [1:0] t, input logic cr);
        exp_t       e;
        logic [1:0] g;
        req = r; req_tail = t; credit_return = cr;
        model_grant(r, g);
        e.grant  = g;
        e.locked = (m_locked != 0);
        e.owner  = 1'(m_owner);
        e.cnt    = 3'(m_cnt);
        e.err    = (m_err != 0);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check_val("grant", 32'(grant), 32'(e.grant));
        check_val("locked", 32'(locked), 32'(e.locked));
        if (e.locked) check_val("owner", 32'(owner), 32'(e.owner));
        check_val("credit_cnt", 32'(credit_cnt), 32'(e.cnt));
        check_val("credit_err", 32'(credit_err), 32'(e.err));
        model_update(g, t, cr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0; req = 2'b11; req_tail = 2'b11; credit_return = 1'b0;
        model_reset();
        #12;
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_owner", 32'(owner), 32'd0);
        check_val("rst_cnt", 32'(credit_cnt), 32'd4);
        check_val("rst_err", 32'(credit_err), 32'd0);
        req = 2'b00;
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;

        // first arbitration from rr_ptr=0, then hand pointer back to 0
        cyc(2'b11, 2'b11, 1'b0);
        cyc(2'b10, 2'b10, 1'b1);
        // wormhole: input0 3-flit packet with a bubble, input1 requesting
        cyc(2'b11, 2'b00, 1'b1);
        cyc(2'b11, 2'b00, 1'b1);
        cyc(2'b10, 2'b00, 1'b1);
        cyc(2'b11, 2'b01, 1'b0);
        cyc(2'b11, 2'b11, 1'b1);
        // fairness with single-flit packets
        for (int i = 0; i < 4; i++) cyc(2'b11, 2'b11, 1'b1);
        cyc(2'b00, 2'b00, 1'b1);
        // credit stall: input1 6-flit packet with no returns
        for (int i = 0; i < 4; i++) cyc(2'b10, 2'b00, 1'b0);
        cyc(2'b10, 2'b00, 1'b0);
        cyc(2'b10, 2'b00, 1'b1);
        cyc(2'b10, 2'b00, 1'b1);
        cyc(2'b10, 2'b10, 1'b1);
        // refill then overflow return
        for (int i = 0; i < 3; i++) cyc(2'b00, 2'b00, 1'b1);
        cyc(2'b00, 2'b00, 1'b1);
        cyc(2'b00, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 1'b0);
        // build a lock on owner 1 with one credit left
        cyc(2'b01, 2'b01, 1'b0);
        cyc(2'b10, 2'b00, 1'b0);
        cyc(2'b10, 2'b00, 1'b0);
        req = 2'b10; req_tail = 2'b00;
        check_val("pre_locked", 32'(locked), 32'd1);
        check_val("pre_owner", 32'(owner), 32'd1);
        check_val("pre_cnt", 32'(credit_cnt), 32'd1);
        rst_b = 1'b0;
        #1;
        check_val("mid_rst_grant", 32'(grant), 32'd0);
        check_val("mid_rst_locked", 32'(locked), 32'd0);
        check_val("mid_rst_cnt", 32'(credit_cnt), 32'd4);
        check_val("mid_rst_err", 32'(credit_err), 32'd0);
        model_reset();
        req = 2'b00;
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;
        cyc(2'b11, 2'b11, 1'b0);
        cyc(2'b11, 2'b11, 1'b0);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
